// File: rtl/digit_entry_ctrl_if.sv
// rtl/digit_entry_ctrl_if.sv - keypad-side and memory-side signals of the digit entry sequencer
//
// Purpose: bundles the key input pulse and the registered write/status outputs.
// Ports (signals):
//   key_valid  one-cycle pulse per debounced key press
//   key_code   0-9 digit, A enter, C clear, others ignored
//   digit      value written while sel != 0
//   sel        one-hot write strobe (0001 left1 .. 1000 right0)
//   cursor     one-hot next position, 0000 when full or busy
//   full       all four digits entered
//   busy       clear sweep in progress
//   go         one-cycle pulse, enter pressed while full
// Modports: master drives keys (keypad side), slave is the sequencer.
interface digit_entry_ctrl_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic [3:0] digit;
    logic [3:0] sel;
    logic [3:0] cursor;
    logic       full;
    logic       busy;
    logic       go;

    modport master (
        output key_valid, key_code,
        input  digit, sel, cursor, full, busy, go
    );

    modport slave (
        input  key_valid, key_code,
        output digit, sel, cursor, full, busy, go
    );
endinterface

// File: rtl/digit_entry_ctrl.sv
// rtl/digit_entry_ctrl.sv - keypad digit entry sequencer for four one-digit operand memories
//
// Purpose: turns key pulses into one-cycle one-hot write strobes that fill
//   left1 -> left0 -> right1 -> right0, sweeps all four to zero on clear or
//   on an inactivity timeout mid-entry, and pulses go on enter when full.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous reset, active-high
//   bus  digit_entry_ctrl_if.slave: key_valid/key_code in;
//        digit/sel/cursor/full/busy/go out, all registered
// Parameters:
//   TIMEOUT_CYC  idle cycles allowed mid-entry before auto-clear
//   CNT_W        timeout counter width, must hold TIMEOUT_CYC
module digit_entry_ctrl #(
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int CNT_W       = 27
) (
    input  logic                clk,
    input  logic                rst,
    digit_entry_ctrl_if.slave   bus
);

    // POS0..POS3 take encodings 0..3 so state[1:0] is the position index.
    typedef enum logic [2:0] {
        POS0 = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        POS3 = 3'd3,
        DONE = 3'd4,
        CLR  = 3'd5
    } state_t;

    localparam logic [3:0]       KEY_ENTER  = 4'hA;
    localparam logic [3:0]       KEY_CLEAR  = 4'hC;
    localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state;
    logic [1:0]       sweep_idx;
    logic [CNT_W-1:0] timer;

    logic in_pos;
    logic timing;
    logic key_digit;
    logic key_enter;
    logic key_clear;
    logic expired;
    logic start_clear;

    function automatic logic [3:0] onehot(input logic [1:0] k);
        return 4'b0001 << k;
    endfunction

    assign in_pos    = (state == POS0) || (state == POS1) ||
                       (state == POS2) || (state == POS3);
    assign timing    = (state == POS1) || (state == POS2) || (state == POS3);
    assign key_digit = bus.key_valid && (bus.key_code <= 4'd9) && in_pos;
    assign key_enter = bus.key_valid && (bus.key_code == KEY_ENTER);
    assign key_clear = bus.key_valid && (bus.key_code == KEY_CLEAR) && (state != CLR);
    assign expired   = timing && (timer == TIMER_LAST);
    // An accepted digit on the expiry cycle outranks the timeout.
    assign start_clear = key_clear || (expired && !key_digit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= POS0;
            sweep_idx  <= 2'd0;
            timer      <= '0;
            bus.sel    <= 4'b0000;
            bus.digit  <= 4'd0;
            bus.cursor <= 4'b0001;
            bus.full   <= 1'b0;
            bus.busy   <= 1'b0;
            bus.go     <= 1'b0;
        end else begin
            bus.sel   <= 4'b0000;
            bus.digit <= 4'd0;
            bus.go    <= 1'b0;

            if (start_clear) begin
                // First sweep strobe goes out together with busy.
                state      <= CLR;
                sweep_idx  <= 2'd0;
                timer      <= '0;
                bus.sel    <= 4'b0001;
                bus.cursor <= 4'b0000;
                bus.full   <= 1'b0;
                bus.busy   <= 1'b1;
            end else begin
                case (state)
                    POS0, POS1, POS2, POS3: begin
                        if (key_digit) begin
                            bus.sel   <= onehot(state[1:0]);
                            bus.digit <= bus.key_code;
                            timer     <= '0;
                            if (state == POS3) begin
                                state      <= DONE;
                                bus.cursor <= 4'b0000;
                                bus.full   <= 1'b1;
                            end else begin
                                state      <= state_t'(state + 3'd1);
                                bus.cursor <= onehot(state[1:0] + 2'd1);
                            end
                        end else if (timing) begin
                            // Enter and invalid codes do not reload the timer.
                            timer <= timer + 1'b1;
                        end
                    end
                    DONE: begin
                        if (key_enter) begin
                            bus.go <= 1'b1;
                        end
                    end
                    CLR: begin
                        // Keys are dropped for the whole sweep.
                        if (sweep_idx == 2'd3) begin
                            state      <= POS0;
                            sweep_idx  <= 2'd0;
                            bus.busy   <= 1'b0;
                            bus.cursor <= 4'b0001;
                        end else begin
                            sweep_idx <= sweep_idx + 2'd1;
                            bus.sel   <= onehot(sweep_idx + 2'd1);
                        end
                    end
                    default: begin
                        state      <= POS0;
                        sweep_idx  <= 2'd0;
                        timer      <= '0;
                        bus.cursor <= 4'b0001;
                        bus.full   <= 1'b0;
                        bus.busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_digit_entry_ctrl.sv
// tb/tb_digit_entry_ctrl.sv - self-checking bench for digit_entry_ctrl with a count-based reference model
module tb_digit_entry_ctrl;

    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    digit_entry_ctrl_if bus();

    digit_entry_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(27)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: how many digits are entered, how far a sweep has got,
    // and how long the entry has been idle.
    int filled;
    int sweep_pos;
    int idle;
    logic [3:0] m_sel, m_digit, m_cursor;
    logic       m_full, m_busy, m_go;

    function automatic logic [14:0] exp_vec();
        return {m_sel, m_digit, m_cursor, m_full, m_busy, m_go};
    endfunction

    function automatic logic [14:0] obs_vec();
        return {bus.sel, bus.digit, bus.cursor, bus.full, bus.busy, bus.go};
    endfunction

    task automatic model_reset();
        filled = 0; sweep_pos = 0; idle = 0;
        m_sel = 4'b0000; m_digit = 4'd0; m_cursor = 4'b0001;
        m_full = 1'b0; m_busy = 1'b0; m_go = 1'b0;
    endtask

    task automatic model_step(input logic kv, input logic [3:0] kc);
        m_sel = 4'b0000; m_digit = 4'd0; m_go = 1'b0;
        if (sweep_pos > 0) begin
            if (sweep_pos < 4) begin
                m_sel = 4'(1 << sweep_pos);
                sweep_pos++;
            end else begin
                sweep_pos = 0;
            end
        end else if (kv && kc <= 4'd9 && filled < 4) begin
            m_sel   = 4'(1 << filled);
            m_digit = kc;
            filled++;
            idle = 0;
        end else if ((kv && kc == 4'hC) || (filled >= 1 && filled <= 3 && idle == TO - 1)) begin
            sweep_pos = 1;
            m_sel  = 4'b0001;
            filled = 0;
            idle   = 0;
        end else begin
            if (kv && kc == 4'hA && filled == 4) m_go = 1'b1;
            if (filled >= 1 && filled <= 3) idle++;
        end
        m_busy   = (sweep_pos > 0);
        m_full   = (filled == 4) && (sweep_pos == 0);
        m_cursor = (sweep_pos == 0 && filled < 4) ? 4'(1 << filled) : 4'b0000;
    endtask

    task automatic tick(input logic kv, input logic [3:0] kc);
        bus.key_valid = kv;
        bus.key_code  = kc;
        @(posedge clk);
        model_step(kv, kc);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_vec() !== {4'b0000, 4'd0, 4'b0001, 3'b000}) begin
            failures++;
            $display("FAIL reset_values got=%b exp=%b", obs_vec(), {4'b0000, 4'd0, 4'b0001, 3'b000});
        end
        #3 rst = 1'b0;
        model_reset();
    endtask

    task automatic test_entry();
        logic [3:0] keys [4] = '{4'd1, 4'd2, 4'd3, 4'd4};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, keys[i]);
            checks++;
            if (bus.sel !== 4'(1 << i) || bus.digit !== keys[i]) begin
                failures++;
                $display("FAIL entry_strobe i=%0d got sel=%b digit=%0d exp sel=%b digit=%0d",
                         i, bus.sel, bus.digit, 4'(1 << i), keys[i]);
            end
            for (int j = 0; j < 2; j++) begin
                tick(1'b0, 4'd0);
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL entry_model cyc=%0d got=%b exp=%b", cyc, obs_vec(), exp_vec());
                end
            end
        end
        checks++;
        if (bus.full !== 1'b1 || bus.cursor !== 4'b0000) begin
            failures++;
            $display("FAIL entry_full got full=%b cursor=%b exp full=1 cursor=0000", bus.full, bus.cursor);
        end
    endtask

    task automatic test_go();
        tick(1'b1, 4'hA);
        checks++;
        if (bus.go !== 1'b1) begin
            failures++;
            $display("FAIL go_pulse got=%b exp=1", bus.go);
        end
        tick(1'b0, 4'd0);
        checks++;
        if (bus.go !== 1'b0) begin
            failures++;
            $display("FAIL go_one_cycle got=%b exp=0", bus.go);
        end
        tick(1'b1, 4'd7);
        checks++;
        if (bus.sel !== 4'b0000 || bus.full !== 1'b1) begin
            failures++;
            $display("FAIL digit_when_full got sel=%b full=%b exp sel=0000 full=1", bus.sel, bus.full);
        end
    endtask

    task automatic test_clear_sweep();
        tick(1'b1, 4'hC);
        repeat (4) tick(1'b0, 4'd0);
        tick(1'b1, 4'd5);
        tick(1'b1, 4'd6);
        tick(1'b1, 4'hC);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.sel !== 4'(1 << i) || bus.digit !== 4'd0 || bus.busy !== 1'b1) begin
                failures++;
                $display("FAIL sweep_step i=%0d got sel=%b digit=%0d busy=%b exp sel=%b digit=0 busy=1",
                         i, bus.sel, bus.digit, bus.busy, 4'(1 << i));
            end
            // Keys during the sweep, clear included, must be dropped.
            tick(1'b1, (i % 2 == 0) ? 4'hC : 4'(2 + i));
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.sel !== 4'b0000 || bus.cursor !== 4'b0001) begin
            failures++;
            $display("FAIL sweep_end got busy=%b sel=%b cursor=%b exp busy=0 sel=0000 cursor=0001",
                     bus.busy, bus.sel, bus.cursor);
        end
    endtask

    // Counts idle ticks after a digit until busy rises; E may be injected on one tick.
    task automatic sweep_latency(input int e_at, output int k_found);
        k_found = -1;
        for (int k = 1; k <= 20; k++) begin
            tick(k == e_at, (k == e_at) ? 4'hE : 4'd0);
            if (k == e_at) begin
                checks++;
                if (bus.sel !== 4'b0000) begin
                    failures++;
                    $display("FAIL invalid_code_strobe got sel=%b exp 0000", bus.sel);
                end
            end
            if (bus.busy === 1'b1) begin
                k_found = k;
                break;
            end
        end
    endtask

    task automatic test_timeout();
        int k;
        tick(1'b1, 4'd9);
        sweep_latency(0, k);
        checks++;
        if (k != TO) begin
            failures++;
            $display("FAIL timeout_latency got=%0d exp=%0d", k, TO);
        end
        repeat (4) tick(1'b0, 4'd0);
        tick(1'b1, 4'd9);
        repeat (TO - 1) tick(1'b0, 4'd0);
        tick(1'b1, 4'd3);
        checks++;
        if (bus.sel !== 4'b0010 || bus.digit !== 4'd3 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL key_on_expiry got sel=%b digit=%0d busy=%b exp sel=0010 digit=3 busy=0",
                     bus.sel, bus.digit, bus.busy);
        end
        tick(1'b1, 4'hC);
        repeat (4) tick(1'b0, 4'd0);
    endtask

    task automatic test_back_to_back();
        int k;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 4'(i));
            checks++;
            if (bus.sel !== 4'(1 << i) || bus.digit !== 4'(i)) begin
                failures++;
                $display("FAIL b2b_strobe i=%0d got sel=%b digit=%0d exp sel=%b digit=%0d",
                         i, bus.sel, bus.digit, 4'(1 << i), i);
            end
        end
        checks++;
        if (bus.full !== 1'b1) begin
            failures++;
            $display("FAIL b2b_full got=%b exp=1", bus.full);
        end
        tick(1'b1, 4'hC);
        repeat (4) tick(1'b0, 4'd0);
        tick(1'b1, 4'd5);
        sweep_latency(4, k);
        checks++;
        if (k != TO) begin
            failures++;
            $display("FAIL invalid_no_reload got=%0d exp=%0d", k, TO);
        end
        repeat (4) tick(1'b0, 4'd0);
    endtask

    task automatic test_reset_mid_sweep();
        tick(1'b1, 4'hC);
        tick(1'b0, 4'd0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.sel !== 4'b0000 || bus.busy !== 1'b0 || bus.cursor !== 4'b0001) begin
            failures++;
            $display("FAIL reset_mid_sweep got sel=%b busy=%b cursor=%b exp sel=0000 busy=0 cursor=0001",
                     bus.sel, bus.busy, bus.cursor);
        end
        @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        repeat (3) begin
            tick(1'b0, 4'd0);
            checks++;
            if (bus.cursor !== 4'b0001 || bus.busy !== 1'b0 || bus.sel !== 4'b0000) begin
                failures++;
                $display("FAIL after_reset got cursor=%b busy=%b sel=%b exp cursor=0001 busy=0 sel=0000",
                         bus.cursor, bus.busy, bus.sel);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] invalid [4] = '{4'hB, 4'hD, 4'hE, 4'hF};
        for (int n = 0; n < 400; n++) begin
            logic       kv;
            logic [3:0] kc;
            int r;
            kv = ($urandom_range(0, 99) < 40);
            r  = $urandom_range(0, 99);
            if (r < 60)      kc = 4'($urandom_range(0, 9));
            else if (r < 70) kc = 4'hA;
            else if (r < 80) kc = 4'hC;
            else             kc = invalid[$urandom_range(0, 3)];
            tick(kv, kc);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_model cyc=%0d kv=%b kc=%h got=%b exp=%b",
                         cyc, kv, kc, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_entry();
        test_go();
        test_clear_sweep();
        test_timeout();
        test_back_to_back();
        test_reset_mid_sweep();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
